// File: rtl/fejkon_pcie_bar_target.sv
// fejkon_pcie_bar_target: BAR0 completer. Takes decoded memory-request TLPs,
// runs single-DW accesses on an Avalon-MM master and returns in-order read
// completions, with UR completions for malformed reads.
// Optional macro FEJKON_PCIE_BAR_TARGET_STATS_EN adds read/UR statistics counters.
module fejkon_pcie_bar_target #(
    parameter int ADDR_W  = 12,
    parameter int PENDING = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [9:0]                req_len,
    input  logic [7:0]                req_tag,
    input  logic [15:0]               req_rid,
    input  logic [31:0]               req_data,
    output logic [ADDR_W-3:0]         mm_address,
    output logic                      mm_read,
    output logic                      mm_write,
    output logic [31:0]               mm_writedata,
    input  logic                      mm_waitrequest,
    input  logic [31:0]               mm_readdata,
    input  logic                      mm_readdatavalid,
    output logic                      cpl_valid,
    input  logic                      cpl_ready,
    output logic [7:0]                cpl_tag,
    output logic [15:0]               cpl_rid,
    output logic [2:0]                cpl_status,
    output logic [6:0]                cpl_lower_addr,
    output logic [31:0]               cpl_data,
    output logic                      cpl_err_ur_p,
    output logic                      cpl_err_ur_np,
    output logic [$clog2(PENDING):0]  pending
`ifdef FEJKON_PCIE_BAR_TARGET_STATS_EN
    ,
    output logic [15:0]               stat_rd_count,
    output logic [15:0]               stat_ur_count
`endif
);

    localparam int PW = $clog2(PENDING);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(PENDING);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE_WR = 2'd1,
        S_ISSUE_RD = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] rid;
        logic [6:0]  lower_addr;
        logic        ur;
    } trk_t;

    // Only aligned single-DW accesses are executed; everything else is UR.
    function automatic logic f_req_ok(input logic [ADDR_W-1:0] addr, input logic [9:0] len);
        f_req_ok = (addr[1:0] == 2'b00) && (len == 10'd1);
    endfunction

    state_t      r_state, w_state_nxt;
    logic        r_req_ready;
    logic        r_mm_read, r_mm_write;
    logic [ADDR_W-3:0] r_mm_address;
    logic [31:0] r_mm_writedata;
    logic        r_err_p, r_err_np;
    logic [PW:0] r_pending, w_pending_nxt;

    trk_t        r_trk_mem [PENDING];
    logic [PW:0] r_trk_wp, r_trk_rp;
    logic [31:0] r_rdf_mem [PENDING];
    logic [PW:0] r_rdf_wp, r_rdf_rp;

    logic        r_cpl_valid;
    logic [7:0]  r_cpl_tag;
    logic [15:0] r_cpl_rid;
    logic [2:0]  r_cpl_status;
    logic [6:0]  r_cpl_lower_addr;
    logic [31:0] r_cpl_data;

    logic w_accept, w_req_ok, w_trk_push, w_cpl_pop;
    logic w_trk_empty, w_rdf_empty, w_load;
    trk_t w_head;

    assign w_accept    = req_valid && r_req_ready;
    assign w_req_ok    = f_req_ok(req_addr, req_len);
    assign w_trk_push  = w_accept && !req_write;
    assign w_cpl_pop   = r_cpl_valid && cpl_ready;
    assign w_trk_empty = (r_trk_wp == r_trk_rp);
    assign w_rdf_empty = (r_rdf_wp == r_rdf_rp);
    assign w_head      = r_trk_mem[r_trk_rp[PW-1:0]];
    // Output register refills when empty or draining; SC entries also need their data.
    assign w_load      = (!r_cpl_valid || cpl_ready) && !w_trk_empty && (w_head.ur || !w_rdf_empty);

    // Next-state logic: valid requests issue on Avalon, UR requests stay in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_req_ok) begin
                    w_state_nxt = req_write ? S_ISSUE_WR : S_ISSUE_RD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE_WR, S_ISSUE_RD: begin
                if (!mm_waitrequest) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outstanding-read count: reads in on accept, out when a completion is consumed.
    always_comb begin
        w_pending_nxt = r_pending;
        case ({w_trk_push, w_cpl_pop})
            2'b10:   w_pending_nxt = r_pending + (PW+1)'(1);
            2'b01:   w_pending_nxt = r_pending - (PW+1)'(1);
            default: w_pending_nxt = r_pending;
        endcase
    end

    // Control registers: FSM state, ready, Avalon command and UR pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_req_ready    <= 1'b0;
            r_mm_read      <= 1'b0;
            r_mm_write     <= 1'b0;
            r_mm_address   <= '0;
            r_mm_writedata <= 32'd0;
            r_err_p        <= 1'b0;
            r_err_np       <= 1'b0;
            r_pending      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE) && (w_pending_nxt != FULL_CNT);
            r_mm_read   <= (w_state_nxt == S_ISSUE_RD);
            r_mm_write  <= (w_state_nxt == S_ISSUE_WR);
            r_err_p     <= w_accept && req_write && !w_req_ok;
            r_err_np    <= w_accept && !req_write && !w_req_ok;
            r_pending   <= w_pending_nxt;
            if (w_accept && w_req_ok) begin
                r_mm_address   <= req_addr[ADDR_W-1:2];
                r_mm_writedata <= req_write ? req_data : r_mm_writedata;
            end else begin
                r_mm_address   <= r_mm_address;
                r_mm_writedata <= r_mm_writedata;
            end
        end
    end

    // FIFO storage: tracker entries on read accept, read data on each Avalon return.
    always_ff @(posedge clk) begin
        if (w_trk_push) begin
            r_trk_mem[r_trk_wp[PW-1:0]] <= '{tag: req_tag, rid: req_rid,
                                            lower_addr: req_addr[6:0], ur: !w_req_ok};
        end
        if (mm_readdatavalid) begin
            r_rdf_mem[r_rdf_wp[PW-1:0]] <= mm_readdata;
        end
    end

    // FIFO pointers; reset empties both queues and abandons in-flight data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trk_wp <= '0;
            r_trk_rp <= '0;
            r_rdf_wp <= '0;
            r_rdf_rp <= '0;
        end else begin
            r_trk_wp <= r_trk_wp + (PW+1)'(w_trk_push);
            r_trk_rp <= r_trk_rp + (PW+1)'(w_load);
            r_rdf_wp <= r_rdf_wp + (PW+1)'(mm_readdatavalid);
            r_rdf_rp <= r_rdf_rp + (PW+1)'(w_load && !w_head.ur);
        end
    end

    // Completion output register; fields only change on load so they hold under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cpl_valid      <= 1'b0;
            r_cpl_tag        <= 8'd0;
            r_cpl_rid        <= 16'd0;
            r_cpl_status     <= 3'b000;
            r_cpl_lower_addr <= 7'd0;
            r_cpl_data       <= 32'd0;
        end else if (w_load) begin
            r_cpl_valid      <= 1'b1;
            r_cpl_tag        <= w_head.tag;
            r_cpl_rid        <= w_head.rid;
            r_cpl_status     <= w_head.ur ? 3'b001 : 3'b000;
            r_cpl_lower_addr <= w_head.lower_addr;
            r_cpl_data       <= w_head.ur ? 32'd0 : r_rdf_mem[r_rdf_rp[PW-1:0]];
        end else if (w_cpl_pop) begin
            r_cpl_valid      <= 1'b0;
        end else begin
            r_cpl_valid      <= r_cpl_valid;
        end
    end

`ifdef FEJKON_PCIE_BAR_TARGET_STATS_EN
    logic [15:0] r_stat_rd, r_stat_ur;

    // Saturating counters of accepted valid reads and of UR requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_rd <= 16'd0;
            r_stat_ur <= 16'd0;
        end else begin
            if (w_trk_push && w_req_ok && (r_stat_rd != 16'hFFFF)) begin
                r_stat_rd <= r_stat_rd + 16'd1;
            end else begin
                r_stat_rd <= r_stat_rd;
            end
            if (w_accept && !w_req_ok && (r_stat_ur != 16'hFFFF)) begin
                r_stat_ur <= r_stat_ur + 16'd1;
            end else begin
                r_stat_ur <= r_stat_ur;
            end
        end
    end

    assign stat_rd_count = r_stat_rd;
    assign stat_ur_count = r_stat_ur;
`endif

    assign req_ready      = r_req_ready;
    assign mm_address     = r_mm_address;
    assign mm_read        = r_mm_read;
    assign mm_write       = r_mm_write;
    assign mm_writedata   = r_mm_writedata;
    assign cpl_valid      = r_cpl_valid;
    assign cpl_tag        = r_cpl_tag;
    assign cpl_rid        = r_cpl_rid;
    assign cpl_status     = r_cpl_status;
    assign cpl_lower_addr = r_cpl_lower_addr;
    assign cpl_data       = r_cpl_data;
    assign cpl_err_ur_p   = r_err_p;
    assign cpl_err_ur_np  = r_err_np;
    assign pending        = r_pending;

endmodule
